// File: rtl/banked_memory_ctrl_if.sv
// Request/response bundle for banked_memory_ctrl: one valid/ready request port
// plus the registered read-data, read-valid and error strobes.
interface banked_memory_ctrl_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_SIZE = 6,
  parameter int unsigned BANK_SEL  = 3
);
  logic                          valid;
  logic                          ready;
  logic                          wr_rd;
  logic                          bcast;
  logic [BANK_SEL+ADDR_SIZE-1:0] addr;
  logic [WIDTH-1:0]              wdata;
  logic                          init_req;
  logic [WIDTH-1:0]              rdata;
  logic                          rvalid;
  logic                          err;

  modport master (
    output valid, wr_rd, bcast, addr, wdata, init_req,
    input  ready, rdata, rvalid, err
  );

  modport slave (
    input  valid, wr_rd, bcast, addr, wdata, init_req,
    output ready, rdata, rvalid, err
  );
endinterface

// File: rtl/banked_memory_ctrl.sv
// Banked memory controller: NUM_BANKS x DEPTH x WIDTH flop storage behind one valid/ready port,
// with self-clearing INIT sequence, broadcast writes and out-of-range error flagging.
module banked_memory_ctrl #(
  parameter int unsigned NUM_BANKS = 8,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_SIZE = 6,
  parameter int unsigned BANK_SEL  = 3
) (
  input logic                  clk,
  input logic                  rst,
  banked_memory_ctrl_if.slave  bus
);

  localparam int unsigned AddrW = BANK_SEL + ADDR_SIZE;

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e               state_q, state_d;
  logic [ADDR_SIZE-1:0] init_cnt_q, init_cnt_d;
  logic                 ready_q, ready_d;
  logic                 rvalid_q, rvalid_d;
  logic                 err_q, err_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;

  logic [WIDTH-1:0]     mem_q [NUM_BANKS][DEPTH];
  logic [NUM_BANKS-1:0] mem_we;
  logic [ADDR_SIZE-1:0] mem_idx;
  logic [WIDTH-1:0]     mem_wdata;

  logic [BANK_SEL-1:0]  bank;
  logic [ADDR_SIZE-1:0] word;
  logic                 bank_ok, word_ok, accept;
  logic [WIDTH-1:0]     rd_word;

  assign bank    = bus.addr[AddrW-1 -: BANK_SEL];
  assign word    = bus.addr[ADDR_SIZE-1:0];
  assign bank_ok = 32'(bank) < NUM_BANKS;
  assign word_ok = 32'(word) < DEPTH;
  assign accept  = ready_q & bus.valid;

  // Out-of-range addresses never match a bank here, so they read back as zero.
  always_comb begin
    rd_word = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (bank == BANK_SEL'(b) && word_ok) rd_word = mem_q[b][word];
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ready_d    = ready_q;
    rvalid_d   = 1'b0;
    err_d      = 1'b0;
    rdata_d    = rdata_q;
    mem_we     = '0;
    mem_idx    = word;
    mem_wdata  = bus.wdata;

    unique case (state_q)
      StInit: begin
        mem_we     = '1;
        mem_idx    = init_cnt_q;
        mem_wdata  = '0;
        init_cnt_d = init_cnt_q + ADDR_SIZE'(1);
        if (init_cnt_q == ADDR_SIZE'(DEPTH - 1)) begin
          state_d    = StRun;
          ready_d    = 1'b1;
          init_cnt_d = '0;
        end
      end
      StRun: begin
        if (accept) begin
          if (bus.wr_rd) begin
            if (word_ok && bus.bcast) begin
              mem_we = '1;
            end else if (word_ok && bank_ok) begin
              for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                mem_we[b] = (bank == BANK_SEL'(b));
              end
            end else begin
              err_d = 1'b1;
            end
          end else begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
            err_d    = ~(word_ok & bank_ok);
          end
        end
        // A request accepted on this edge still completes; re-init starts next cycle.
        if (bus.init_req) begin
          state_d    = StInit;
          ready_d    = 1'b0;
          init_cnt_d = '0;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ready_q    <= ready_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
  end

  // Storage has no reset; contents change only through INIT clears and accepted writes.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (rst && mem_we[b]) mem_q[b][mem_idx] <= mem_wdata;
    end
  end

  assign bus.ready  = ready_q;
  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;
  assign bus.rdata  = rdata_q;

endmodule

// File: tb/tb_banked_memory_ctrl.sv
// Scoreboard bench for banked_memory_ctrl (6 banks so out-of-range banks exist): a plain
// array model predicts responses, a negedge monitor pops and compares them.
module tb_banked_memory_ctrl;
  localparam int unsigned NB = 6;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned W = 8;
  localparam int unsigned AS = 6;
  localparam int unsigned BS = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  banked_memory_ctrl_if #(.WIDTH(W), .ADDR_SIZE(AS), .BANK_SEL(BS)) bus ();

  banked_memory_ctrl #(
    .NUM_BANKS(NB), .DEPTH(DEPTH), .WIDTH(W), .ADDR_SIZE(AS), .BANK_SEL(BS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int           due;
    bit           rv;
    bit           er;
    logic [W-1:0] d;
  } exp_t;

  exp_t         sb[$];
  int           n_vec = 0;
  int           n_miss = 0;
  int           mon_cnt = 0;
  bit           mon_en = 1'b0;
  bit           m_ready = 1'b0;
  int           init_left = 0;
  logic [W-1:0] m_mem[8][DEPTH];
  logic [W-1:0] last_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int b = 0; b < 8; b++)
      for (int w = 0; w < int'(DEPTH); w++) m_mem[b][w] = '0;
  endtask

  // Monitor: each negedge either a scheduled response is due or all strobes must be quiet.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      mon_cnt++;
      if (sb.size() != 0 && sb[0].due == mon_cnt) begin
        e = sb.pop_front();
        if (e.rv) last_rdata = e.d;
        chk("resp", {22'd0, bus.rvalid, bus.err, bus.rdata}, {22'd0, e.rv, e.er, last_rdata});
      end else begin
        chk("idle", {22'd0, bus.rvalid, bus.err, bus.rdata}, {22'd0, 2'b00, last_rdata});
      end
    end
  end

  task automatic step(input bit v, input bit w, input bit bc,
                      input logic [BS+AS-1:0] a, input logic [W-1:0] d, input bit ir);
    int   bk;
    int   wd;
    bit   inr;
    exp_t e;
    @(negedge clk);
    chk("ready", {31'd0, bus.ready}, {31'd0, m_ready});
    bus.valid    = v;
    bus.wr_rd    = w;
    bus.bcast    = bc;
    bus.addr     = a;
    bus.wdata    = d;
    bus.init_req = ir;
    @(posedge clk);
    if (m_ready) begin
      if (v) begin
        bk  = int'(a[BS+AS-1 -: BS]);
        wd  = int'(a[AS-1:0]);
        inr = (bk < int'(NB)) && (wd < int'(DEPTH));
        e.due = mon_cnt + 1;
        if (w) begin
          if (bc && wd < int'(DEPTH)) begin
            for (int b = 0; b < int'(NB); b++) m_mem[b][wd] = d;
          end else if (inr) begin
            m_mem[bk][wd] = d;
          end else begin
            e.rv = 1'b0; e.er = 1'b1; e.d = '0;
            sb.push_back(e);
          end
        end else begin
          e.rv = 1'b1; e.er = !inr; e.d = inr ? m_mem[bk][wd] : '0;
          sb.push_back(e);
        end
      end
      if (ir) begin
        m_ready   = 1'b0;
        init_left = DEPTH;
        clear_model();
      end
    end else if (init_left > 0) begin
      init_left--;
      if (init_left == 0) m_ready = 1'b1;
    end
  endtask

  task automatic rd(input int bk, input int wd);
    step(1'b1, 1'b0, 1'b0, {3'(bk), 6'(wd)}, '0, 1'b0);
  endtask

  task automatic wr(input int bk, input int wd, input logic [W-1:0] d, input bit bc);
    step(1'b1, 1'b1, bc, {3'(bk), 6'(wd)}, d, 1'b0);
  endtask

  // Asserts rst shortly after a clock edge and releases it after the next one.
  task automatic do_reset();
    #2 rst = 1'b0;
    sb.delete();
    last_rdata = '0;
    m_ready    = 1'b0;
    init_left  = 0;
    #1 chk("rst_async", {20'd0, bus.ready, bus.rvalid, bus.err, 1'b0, bus.rdata}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    init_left = DEPTH;
    clear_model();
  endtask

  initial begin
    bus.valid = 1'b0; bus.wr_rd = 1'b0; bus.bcast = 1'b0;
    bus.addr = '0; bus.wdata = '0; bus.init_req = 1'b0;
    clear_model();
    #1 rst = 1'b0;
    #1 chk("rst_vals", {20'd0, bus.ready, bus.rvalid, bus.err, 1'b0, bus.rdata}, 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    init_left = DEPTH;
    mon_en    = 1'b1;

    // INIT with valid held high, then a read of a cleared word.
    repeat (66) rd(3, 10);

    wr(5, 63, 8'hA5, 1'b0);
    rd(5, 63);
    rd(4, 63);

    // Broadcast (bank bits ignored) followed by back-to-back reads of every bank select.
    wr(7, 7, 8'h3C, 1'b1);
    for (int b = 0; b < 8; b++) rd(b, 7);

    // Non-existent banks.
    rd(6, 0);
    wr(7, 0, 8'h11, 1'b0);
    for (int b = 0; b < 8; b++) rd(b, 0);

    // init_req together with a read: the read completes with old data, then memory is cleared.
    wr(2, 2, 8'hFF, 1'b0);
    step(1'b1, 1'b0, 1'b0, {3'd2, 6'd2}, '0, 1'b1);
    repeat (64) wr($urandom_range(0, 7), $urandom_range(0, 63), 8'($urandom), 1'b0);
    rd(2, 2);
    rd(2, 2);

    // Random traffic on a few words so reads frequently hit earlier writes.
    repeat (400) begin
      step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
           {3'($urandom_range(0, 7)), 6'($urandom_range(0, 3))}, 8'($urandom),
           ($urandom_range(0, 99) == 0));
    end

    // Async reset while a read response is pending.
    wr(1, 1, 8'h5A, 1'b0);
    rd(1, 1);
    do_reset();
    repeat (66) rd(1, 1);

    repeat (3) step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
